// File: rtl/dotprod_sched_pkg.sv
// rtl/dotprod_sched_pkg.sv - shared state encoding and defaults for the dotprod scheduler
package dotprod_sched_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam int DEFAULT_LATENCY = 64;
  localparam int DEFAULT_W       = 32;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting at ptr
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx
);

  logic           found;
  logic [IDW-1:0] idx;

  // Scan cyclically from ptr and keep the first asserted request.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IDW'((int'(ptr) + k) % NREQ);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/dotprod_sched.sv
// rtl/dotprod_sched.sv - shares one reset-started dotprod core between requesters
module dotprod_sched
  import dotprod_sched_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int W       = DEFAULT_W,
  parameter int LATENCY = DEFAULT_LATENCY,
  parameter int CNT_W   = 16,
  parameter int IDW     = $clog2(NREQ)
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_n,
  output logic [NREQ-1:0]   req_ready,
  output logic              core_rst_n,
  output logic [W-1:0]      core_n,
  input  logic [W-1:0]      core_ret,
  output logic              rsp_valid,
  output logic [IDW-1:0]    rsp_id,
  output logic [W-1:0]      rsp_val,
  input  logic              rsp_ready,
  output logic              busy
);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [W-1:0]     core_n_q, core_n_d;
  logic             core_rst_n_q, core_rst_n_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic [W-1:0]     rsp_val_q, rsp_val_d;

  logic [NREQ-1:0]  grant;
  logic [IDW-1:0]   grant_idx;
  logic [W-1:0]     sel_n;
  logic             accept;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req       (req_valid),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Operand of the current winner.
  always_comb begin
    sel_n = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx == IDW'(i)) sel_n = req_n[i*W +: W];
    end
  end

  // State register plus operand/result/counter flops, synchronous reset.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      ptr_q        <= '0;
      core_n_q     <= '0;
      core_rst_n_q <= 1'b0;
      rsp_id_q     <= '0;
      rsp_val_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ptr_q        <= ptr_d;
      core_n_q     <= core_n_d;
      core_rst_n_q <= core_rst_n_d;
      rsp_id_q     <= rsp_id_d;
      rsp_val_q    <= rsp_val_d;
    end
  end

  // Next state and datapath: accept, count out the core latency, hand off result.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ptr_d        = ptr_q;
    core_n_d     = core_n_q;
    core_rst_n_d = core_rst_n_q;
    rsp_id_d     = rsp_id_q;
    rsp_val_d    = rsp_val_q;
    accept       = (state_q == ST_IDLE) && (|(req_valid & grant));
    case (state_q)
      ST_IDLE: begin
        core_rst_n_d = 1'b0;
        if (accept) begin
          core_n_d = sel_n;
          rsp_id_d = grant_idx;
          ptr_d    = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
          cnt_d    = '0;
          if (sel_n != '0) begin
            // Releasing the core reset is what starts the computation.
            core_rst_n_d = 1'b1;
            state_d      = ST_RUN;
          end else begin
            // n==0 has a trivial result; skip the core entirely.
            rsp_val_d = '0;
            state_d   = ST_RESP;
          end
        end
      end
      ST_RUN: begin
        core_rst_n_d = 1'b1;
        cnt_d        = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(LATENCY - 1)) begin
          rsp_val_d = core_ret;
          state_d   = ST_RESP;
        end
      end
      ST_RESP: begin
        // Core stays released so return_val does not change while we wait.
        if (rsp_ready) begin
          core_rst_n_d = 1'b0;
          state_d      = ST_IDLE;
        end
      end
      default: begin
        core_rst_n_d = 1'b0;
        state_d      = ST_IDLE;
      end
    endcase
  end

  // Outputs decoded from state; grants are suppressed while in reset.
  always_comb begin
    req_ready  = (state_q == ST_IDLE && sys_rst_n) ? grant : '0;
    rsp_valid  = (state_q == ST_RESP);
    busy       = (state_q != ST_IDLE);
    core_rst_n = core_rst_n_q;
    core_n     = core_n_q;
    rsp_id     = rsp_id_q;
    rsp_val    = rsp_val_q;
  end

endmodule

// File: tb/tb_dotprod_sched.sv
// tb/tb_dotprod_sched.sv - directed self-checking bench for dotprod_sched
module tb_dotprod_sched;

  localparam int NREQ    = 2;
  localparam int W       = 32;
  localparam int LATENCY = 64;
  localparam int CNT_W   = 16;
  localparam int IDW     = 1;

  logic              clk = 1'b0;
  logic              sys_rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_n;
  logic [NREQ-1:0]   req_ready;
  logic              core_rst_n;
  logic [W-1:0]      core_n;
  logic [W-1:0]      core_ret;
  logic              rsp_valid;
  logic [IDW-1:0]    rsp_id;
  logic [W-1:0]      rsp_val;
  logic              rsp_ready;
  logic              busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int rc       = 0;

  always #5 clk = ~clk;

  dotprod_sched #(
    .NREQ(NREQ), .W(W), .LATENCY(LATENCY), .CNT_W(CNT_W), .IDW(IDW)
  ) dut (
    .sys_clk    (clk),
    .sys_rst_n  (sys_rst_n),
    .req_valid  (req_valid),
    .req_n      (req_n),
    .req_ready  (req_ready),
    .core_rst_n (core_rst_n),
    .core_n     (core_n),
    .core_ret   (core_ret),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_val    (rsp_val),
    .rsp_ready  (rsp_ready),
    .busy       (busy)
  );

  function automatic logic [31:0] sq_sum(input logic [31:0] n);
    logic [31:0] s;
    s = 0;
    for (int i = 1; i <= int'(n); i++) s = s + 32'(i * i);
    return s;
  endfunction

  // Core model: result only valid once LATENCY released cycles have elapsed.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!core_rst_n) rc <= 0;
    else rc <= rc + 1;
  end
  assign core_ret = (core_rst_n && rc >= LATENCY - 1) ? sq_sum(core_n) : 32'hDEAD_BEEF;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_rsp(output int waited);
    waited = 0;
    while (!rsp_valid && waited < 300) begin
      step();
      waited++;
    end
    if (!rsp_valid) chk("rsp_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    int w;
    int prev_cyc;
    int lowcnt;
    logic [IDW-1:0] exp_id;

    sys_rst_n = 1'b0;
    req_valid = 2'b11;
    req_n     = {32'd3, 32'd10};
    rsp_ready = 1'b0;
    step(); step(); step();
    chk("reset_core_rst_n", core_rst_n, 0);
    chk("reset_core_n", core_n, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_id", rsp_id, 0);
    chk("reset_rsp_val", rsp_val, 0);
    chk("reset_busy", busy, 0);
    chk("reset_req_ready", req_ready, 0);

    // Single request from requester 0, n=10.
    req_valid = 2'b01;
    sys_rst_n = 1'b1;
    #1;
    chk("single_grant", req_ready, 2'b01);
    step();
    req_valid = 2'b00;
    chk("single_core_rst_n", core_rst_n, 1);
    chk("single_core_n", core_n, 10);
    chk("single_busy", busy, 1);
    chk("single_req_ready_run", req_ready, 0);
    wait_rsp(w);
    chk("single_latency", w, 64);
    chk("single_rsp_id", rsp_id, 0);
    chk("single_rsp_val", rsp_val, 385);

    // Backpressure while both requesters wait.
    req_valid = 2'b11;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("bp_hold", {rsp_valid, core_rst_n, req_ready, rsp_id, rsp_val},
          {1'b1, 1'b1, 2'b00, 1'b0, 32'd385});
    end
    rsp_ready = 1'b1;
    step();
    chk("consume_core_rst_n", core_rst_n, 0);
    chk("consume_busy", busy, 0);
    chk("consume_grant_ptr1", req_ready, 2'b10);

    // Contention: both held, rotating grants 1,0,1,0 with the core restarted between jobs.
    prev_cyc = 0;
    exp_id   = 1'b1;
    for (int j = 0; j < 4; j++) begin
      wait_rsp(w);
      chk("cont_rsp_id", rsp_id, exp_id);
      chk("cont_rsp_val", rsp_val, exp_id ? 32'd14 : 32'd385);
      if (j > 0) chk("cont_spacing", cyc - prev_cyc, 66);
      prev_cyc = cyc;
      exp_id   = ~exp_id;
      step();
      lowcnt = 0;
      while (!core_rst_n && lowcnt < 10) begin
        lowcnt++;
        step();
      end
      chk("cont_reset_gap", lowcnt, 1);
    end
    req_valid = 2'b00;
    wait_rsp(w);
    chk("cont_last_id", rsp_id, 1);
    chk("cont_last_val", rsp_val, 14);
    chk("cont_last_spacing", cyc - prev_cyc, 66);
    step();
    chk("cont_idle", busy, 0);

    // n==0 from requester 1: ptr is 0, only requester 1 pending.
    req_n     = {32'd0, 32'd10};
    req_valid = 2'b10;
    #1;
    chk("zero_grant", req_ready, 2'b10);
    step();
    req_valid = 2'b00;
    chk("zero_rsp_valid", rsp_valid, 1);
    chk("zero_rsp_val", rsp_val, 0);
    chk("zero_rsp_id", rsp_id, 1);
    chk("zero_core_rst_n", core_rst_n, 0);
    step();
    chk("zero_core_rst_n_after", core_rst_n, 0);
    chk("zero_idle", {busy, rsp_valid}, 2'b00);

    // Mid-run reset at cnt=30 after granting requester 0 (ptr becomes 1).
    req_n     = {32'd3, 32'd10};
    req_valid = 2'b01;
    step();
    req_valid = 2'b00;
    for (int i = 0; i < 30; i++) step();
    chk("mid_running", {busy, core_rst_n}, 2'b11);
    sys_rst_n = 1'b0;
    step();
    sys_rst_n = 1'b1;
    chk("mid_reset_state", {busy, core_rst_n, rsp_valid}, 3'b000);
    chk("mid_reset_core_n", core_n, 0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("mid_no_rsp", rsp_valid, 0);
    end
    req_valid = 2'b11;
    #1;
    chk("mid_ptr_restart", req_ready, 2'b01);
    step();
    req_valid = 2'b00;
    wait_rsp(w);
    chk("mid_fresh_latency", w, 64);
    chk("mid_fresh_id", rsp_id, 0);
    chk("mid_fresh_val", rsp_val, 385);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
